// File: rtl/task_scheduler.sv
// ---------------------------------------------------------------------------
// task_scheduler
//
// Feeds one kernel program to the gpu_core array. The host writes a
// PROG_DEPTH-entry program into a local RAM, then launches it with a start
// pulse and a core mask. Each enabled core, in ascending index order, receives
// every program word over a shared instruction bus. A one-hot val_ins strobe
// selects the core. Once every enabled core raises ready, the scheduler drops
// busy and raises done.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        asynchronous, active-low reset
//   prog_we      host program RAM write strobe (honoured only in IDLE/DONE)
//   prog_addr    program RAM write address
//   prog_data    program RAM write data
//   core_mask    cores to dispatch to, sampled on an accepted start
//   start        one-cycle kernel launch pulse
//   core_rtr     per-core ready-to-receive
//   core_ready   per-core kernel-finished flag
//   instruction  shared instruction bus (registered RAM read)
//   val_ins      one-hot per-core instruction-valid strobe
//   busy         high from accepted start until completion
//   done         high after completion until the next accepted start
// ---------------------------------------------------------------------------
module task_scheduler #(
    parameter int NUM_CORES  = 8,
    parameter int PROG_DEPTH = 16,
    parameter int INS_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [INS_W-1:0]              prog_data,
    input  logic [NUM_CORES-1:0]          core_mask,
    input  logic                          start,
    input  logic [NUM_CORES-1:0]          core_rtr,
    input  logic [NUM_CORES-1:0]          core_ready,
    output logic [INS_W-1:0]              instruction,
    output logic [NUM_CORES-1:0]          val_ins,
    output logic                          busy,
    output logic                          done
);

    localparam int IDX_W = $clog2(PROG_DEPTH);
    localparam int CUR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_STREAM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   mask_q, mask_d;
    logic [CUR_W-1:0]       cur_q, cur_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [INS_W-1:0]       instruction_q, instruction_d;

    logic [INS_W-1:0]       prog_mem [PROG_DEPTH];

    logic                   prog_wr_en;
    logic                   beat_acc;
    logic [CUR_W-1:0]       first_cur;
    logic [CUR_W-1:0]       next_cur;
    logic                   next_found;

    // Program RAM: writes are accepted only while no kernel is in flight,
    // so the read port never sees a write during streaming.
    assign prog_wr_en = prog_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk) begin
        if (prog_wr_en) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    // The read address is the next index, so the registered word lines up
    // with the beat the strobe is about to present.
    assign instruction_d = prog_mem[idx_d];

    // The strobe is a combinational gate of the current core's rtr. This lets
    // a stall take effect in the same cycle it is raised.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_val
            assign val_ins[gi] = (state_q == ST_STREAM) && (cur_q == CUR_W'(gi)) && core_rtr[gi];
        end
    endgenerate

    assign beat_acc = |val_ins;

    // Lowest set bit of the incoming mask (first core to serve).
    always_comb begin
        first_cur = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_mask[i]) begin
                first_cur = CUR_W'(i);
            end
        end
    end

    // Lowest set bit of the latched mask strictly above the current core.
    always_comb begin
        next_found = 1'b0;
        next_cur   = cur_q;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_q))) begin
                next_found = 1'b1;
                next_cur   = CUR_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && (core_mask != '0)) begin
                    mask_d  = core_mask;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    cur_d   = first_cur;
                    idx_d   = '0;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (core_rtr[cur_q]) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (beat_acc) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (next_found) begin
                            cur_d   = next_cur;
                            state_d = ST_SELECT;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Ready from cores outside the mask is ignored.
                if ((core_ready & mask_q) == mask_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            mask_q        <= '0;
            cur_q         <= '0;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            instruction_q <= '0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            cur_q         <= cur_d;
            idx_q         <= idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            instruction_q <= instruction_d;
        end
    end

    assign instruction = instruction_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_task_scheduler.sv
// ---------------------------------------------------------------------------
// tb_task_scheduler
//
// Directed bench for task_scheduler. A negedge monitor logs every strobed
// beat with its core vector, data word and cycle number. The scenario tasks
// drive stimulus just after posedge and compare the log and the outputs
// against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_task_scheduler;

    localparam int NC = 8;

    logic        clk;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [7:0]  core_mask;
    logic        start;
    logic [7:0]  core_rtr;
    logic [7:0]  core_ready;
    logic [15:0] instruction;
    logic [7:0]  val_ins;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int bad_onehot = 0;

    logic [7:0]  q_vec[$];
    logic [15:0] q_data[$];
    int          q_cyc[$];

    task_scheduler #(.NUM_CORES(8), .PROG_DEPTH(16), .INS_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .core_mask(core_mask),
        .start(start),
        .core_rtr(core_rtr),
        .core_ready(core_ready),
        .instruction(instruction),
        .val_ins(val_ins),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (val_ins != 8'h00) begin
            q_vec.push_back(val_ins);
            q_data.push_back(instruction);
            q_cyc.push_back(cyc);
            if (!$onehot(val_ins)) bad_onehot++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        q_vec.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic write_prog(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] m);
        core_mask = m;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) until at least n beats are logged; ends at negedge+1.
    task automatic wait_beats(input int n, input string name);
        int t;
        for (t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            if (q_vec.size() >= n) break;
        end
        if (q_vec.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: beats=%0d required=%0d", name, q_vec.size(), n);
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) break;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s done timeout: done=%b required=1", name, done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        core_mask = 8'hFF;
        core_rtr = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (val_ins !== 8'h00) begin errors++; $display("FAIL reset_val_ins: got %h required 00", val_ins); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b required 00", busy, done); end
        checks++;
        if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instruction: got %h required 0000", instruction); end
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || val_ins !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b val_ins=%h required 0 0 00", busy, done, val_ins);
        end
        $display("test_reset complete");
    endtask

    task automatic test_single;
        tick();
        for (int i = 0; i < 16; i++) write_prog(4'(i), 16'h1000 + 16'(i));
        core_ready = 8'h00;
        core_rtr = 8'hFF;
        clear_log();
        pulse_start(8'h01);
        wait_beats(16, "single");
        repeat (3) tick();
        checks++;
        if (q_vec.size() != 16) begin errors++; $display("FAIL single_count: got %0d required 16", q_vec.size()); end
        if (q_vec.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (q_vec[i] !== 8'h01 || q_data[i] !== 16'h1000 + 16'(i)) begin
                    errors++;
                    $display("FAIL single_beat%0d: got vec=%h data=%h required vec=01 data=%h", i, q_vec[i], q_data[i], 16'h1000 + 16'(i));
                end
            end
            checks++;
            if (q_cyc[0] - start_cyc != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", q_cyc[0] - start_cyc); end
            checks++;
            if (q_cyc[15] - q_cyc[0] != 15) begin errors++; $display("FAIL single_consecutive: got span %0d required 15", q_cyc[15] - q_cyc[0]); end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_waiting: busy=%b done=%b required 1 0", busy, done); end
        @(posedge clk);
        #1;
        core_ready = 8'h01;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got %b required 0", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_done: done=%b busy=%b required 1 0", done, busy); end
        $display("test_single complete: %0d beats", q_vec.size());
    endtask

    task automatic test_multi;
        int order[4] = '{0, 2, 5, 7};
        logic [7:0] all_vec;
        tick();
        core_ready = 8'h00;
        bad_onehot = 0;
        clear_log();
        pulse_start(8'hA5);
        wait_beats(64, "multi");
        repeat (3) tick();
        checks++;
        if (q_vec.size() != 64) begin errors++; $display("FAIL multi_count: got %0d required 64", q_vec.size()); end
        all_vec = 8'h00;
        for (int n = 0; n < q_vec.size() && n < 64; n++) begin
            logic [7:0] ev;
            ev = 8'h01 << order[n / 16];
            all_vec = all_vec | q_vec[n];
            checks++;
            if (q_vec[n] !== ev || q_data[n] !== 16'h1000 + 16'(n % 16)) begin
                errors++;
                $display("FAIL multi_beat%0d: got vec=%h data=%h required vec=%h data=%h", n, q_vec[n], q_data[n], ev, 16'h1000 + 16'(n % 16));
            end
        end
        checks++;
        if (all_vec !== 8'hA5) begin errors++; $display("FAIL multi_strobed_set: got %h required a5", all_vec); end
        checks++;
        if (bad_onehot != 0) begin errors++; $display("FAIL multi_onehot: got %0d violations required 0", bad_onehot); end
        core_ready = 8'hA5;
        wait_done("multi");
        $display("test_multi complete: %0d beats", q_vec.size());
    endtask

    task automatic test_stall;
        int zeros;
        tick();
        core_ready = 8'h00;
        core_rtr = 8'hFF;
        clear_log();
        pulse_start(8'h01);
        wait_beats(6, "stall_pre");
        @(posedge clk);
        #1;
        core_rtr = 8'hFE;
        zeros = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (val_ins === 8'h00) zeros++;
            @(posedge clk);
            #1;
        end
        core_rtr = 8'hFF;
        checks++;
        if (zeros != 3) begin errors++; $display("FAIL stall_low_cycles: got %0d required 3", zeros); end
        wait_beats(16, "stall");
        repeat (4) tick();
        checks++;
        if (q_vec.size() != 16) begin errors++; $display("FAIL stall_count: got %0d required 16", q_vec.size()); end
        if (q_vec.size() >= 7) begin
            checks++;
            if (q_data[6] !== 16'h1006) begin errors++; $display("FAIL stall_beat6: got %h required 1006", q_data[6]); end
            checks++;
            if (q_cyc[6] - q_cyc[5] != 4) begin errors++; $display("FAIL stall_gap: got %0d required 4", q_cyc[6] - q_cyc[5]); end
            checks++;
            if (q_data[5] !== 16'h1005) begin errors++; $display("FAIL stall_beat5: got %h required 1005", q_data[5]); end
        end
        core_ready = 8'h01;
        wait_done("stall");
        $display("test_stall complete: %0d beats", q_vec.size());
    endtask

    task automatic test_out_of_order;
        logic [7:0] all_vec;
        tick();
        core_ready = 8'h00;
        core_rtr = 8'hFF;
        clear_log();
        pulse_start(8'h05);
        wait_beats(5, "ooo_pre");
        @(posedge clk);
        #1;
        // start and program write while streaming: both must be ignored
        start = 1'b1;
        core_mask = 8'h02;
        prog_we = 1'b1;
        prog_addr = 4'd3;
        prog_data = 16'hBEEF;
        tick();
        start = 1'b0;
        prog_we = 1'b0;
        wait_beats(32, "ooo");
        repeat (4) tick();
        checks++;
        if (q_vec.size() != 32) begin errors++; $display("FAIL ooo_count: got %0d required 32", q_vec.size()); end
        all_vec = 8'h00;
        for (int n = 0; n < q_vec.size(); n++) all_vec = all_vec | q_vec[n];
        checks++;
        if (all_vec !== 8'h05) begin errors++; $display("FAIL ooo_strobed_set: got %h required 05", all_vec); end
        if (q_vec.size() >= 32) begin
            checks++;
            if (q_vec[15] !== 8'h01 || q_vec[16] !== 8'h04) begin
                errors++;
                $display("FAIL ooo_order: got %h,%h required 01,04", q_vec[15], q_vec[16]);
            end
        end
        core_ready = 8'h04;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ooo_partial_ready: done=%b busy=%b required 0 1", done, busy); end
        @(posedge clk);
        #1;
        core_ready = 8'h05;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ooo_done: done=%b busy=%b required 1 0", done, busy); end
        @(posedge clk);
        #1;
        // zero-mask start leaves DONE untouched
        pulse_start(8'h00);
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || val_ins !== 8'h00) begin
            errors++;
            $display("FAIL ooo_zero_mask_start: done=%b busy=%b val_ins=%h required 1 0 00", done, busy, val_ins);
        end
        @(posedge clk);
        #1;
        write_prog(4'd15, 16'hABCD);
        $display("test_out_of_order complete: %0d beats", q_vec.size());
    endtask

    task automatic test_reset_mid;
        tick();
        core_ready = 8'h00;
        core_rtr = 8'hFF;
        clear_log();
        pulse_start(8'h04);
        wait_beats(10, "rmid_pre");
        reset = 1'b0;
        #1;
        checks++;
        if (val_ins !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || instruction !== 16'h0000) begin
            errors++;
            $display("FAIL rmid_async_clear: val_ins=%h busy=%b done=%b ins=%h required 00 0 0 0000", val_ins, busy, done, instruction);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        clear_log();
        pulse_start(8'h04);
        wait_beats(16, "rmid");
        repeat (3) tick();
        checks++;
        if (q_vec.size() != 16) begin errors++; $display("FAIL rmid_count: got %0d required 16", q_vec.size()); end
        if (q_vec.size() == 16) begin
            checks++;
            if (q_data[0] !== 16'h1000 || q_vec[0] !== 8'h04) begin errors++; $display("FAIL rmid_first: vec=%h data=%h required 04 1000", q_vec[0], q_data[0]); end
            checks++;
            if (q_data[3] !== 16'h1003) begin errors++; $display("FAIL rmid_dropped_write: got %h required 1003", q_data[3]); end
            checks++;
            if (q_data[15] !== 16'hABCD) begin errors++; $display("FAIL rmid_done_write: got %h required abcd", q_data[15]); end
        end
        core_ready = 8'h04;
        wait_done("rmid");
        $display("test_reset_mid complete: %0d beats", q_vec.size());
    endtask

    initial begin
        reset = 1'b0;
        prog_we = 1'b0;
        prog_addr = 4'd0;
        prog_data = 16'h0000;
        core_mask = 8'h00;
        start = 1'b0;
        core_rtr = 8'h00;
        core_ready = 8'h00;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_out_of_order();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
